// File: rtl/udp_ip_pkg.sv
// Shared constants and FSM encoding for the UDP receive/transmit stages.
// Imported by rx_udp_analy and tx_udp_pack.
package udp_ip_pkg;

    localparam int UDP_HDR_WORDS = 2;
    localparam int UDP_HDR_BYTES = 8;
    localparam int MTY_W         = 2;
    localparam int WORD_BYTES    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2
    } udp_state_e;

endpackage

// File: rtl/rx_udp_analy.sv
// UDP receive stage: parses the 8-byte header, checks ports and length,
// strips the header and forwards the payload with re-framed sop/eop/mty.
module rx_udp_analy
    import udp_ip_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cfg_port_local,
    input  logic [15:0]       cfg_port_pc,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [MTY_W-1:0]  din_mty,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [MTY_W-1:0]  dout_mty,
    output logic              flag_port_local_err,
    output logic              flag_port_pc_err,
    output logic              flag_len_err
);

    udp_state_e       state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] udp_len_q;
    logic             first_q;
    logic             pc_err_q;
    logic             loc_err_q;

    logic             pc_err_w;
    logic             loc_err_w;
    logic [LEN_W:0]   sum_w;
    logic [LEN_W-1:0] nxt_cnt;
    logic [LEN_W-1:0] rx_bytes;
    logic [LEN_W-1:0] len_field;

    assign pc_err_w  = din[DATA_W-1 -: 16] != cfg_port_pc;
    assign loc_err_w = din[15:0] != cfg_port_local;
    assign len_field = din[DATA_W-1 -: LEN_W];

    // Byte count saturates at all-ones; a saturated count stays saturated
    always_comb begin
        sum_w   = {1'b0, cnt} + (LEN_W+1)'(WORD_BYTES);
        nxt_cnt = sum_w[LEN_W] ? '1 : sum_w[LEN_W-1:0];
        if (nxt_cnt == '1)
            rx_bytes = '1;
        else
            rx_bytes = nxt_cnt - LEN_W'(din_mty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            udp_len_q           <= '0;
            first_q             <= 1'b0;
            pc_err_q            <= 1'b0;
            loc_err_q           <= 1'b0;
            dout                <= '0;
            dout_vld            <= 1'b0;
            dout_sop            <= 1'b0;
            dout_eop            <= 1'b0;
            dout_mty            <= '0;
            flag_port_local_err <= 1'b0;
            flag_port_pc_err    <= 1'b0;
            flag_len_err        <= 1'b0;
        end else begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_mty <= '0;
            if (din_vld && din_sop) begin
                // A sop mid-packet aborts the packet in flight
                if (state != IDLE) begin
                    flag_port_pc_err    <= pc_err_q;
                    flag_port_local_err <= loc_err_q;
                    flag_len_err        <= 1'b1;
                    if (state == DATA && !first_q) begin
                        dout_vld <= 1'b1;
                        dout_eop <= 1'b1;
                    end
                end
                pc_err_q  <= pc_err_w;
                loc_err_q <= loc_err_w;
                cnt       <= LEN_W'(WORD_BYTES);
                first_q   <= 1'b1;
                if (din_eop) begin
                    flag_port_pc_err    <= pc_err_w;
                    flag_port_local_err <= loc_err_w;
                    flag_len_err        <= 1'b1;
                    state               <= IDLE;
                end else begin
                    state <= HDR1;
                end
            end else if (din_vld) begin
                unique case (state)
                    HDR1: begin
                        udp_len_q <= len_field;
                        cnt       <= nxt_cnt;
                        first_q   <= 1'b1;
                        if (din_eop) begin
                            flag_port_pc_err    <= pc_err_q;
                            flag_port_local_err <= loc_err_q;
                            flag_len_err        <= rx_bytes != len_field;
                            state               <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        dout     <= din;
                        dout_vld <= 1'b1;
                        dout_sop <= first_q;
                        dout_eop <= din_eop;
                        dout_mty <= din_eop ? din_mty : '0;
                        first_q  <= 1'b0;
                        cnt      <= nxt_cnt;
                        if (din_eop) begin
                            flag_port_pc_err    <= pc_err_q;
                            flag_port_local_err <= loc_err_q;
                            flag_len_err        <= rx_bytes != udp_len_q;
                            state               <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_udp_analy.sv
// Directed bench for rx_udp_analy with an output and flag scoreboard.
// Expected words/flags are queued at drive time and checked on output.
module tb_rx_udp_analy;
    import udp_ip_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_port_local;
    logic [15:0] cfg_port_pc;
    logic [31:0] din;
    logic        din_vld;
    logic        din_sop;
    logic        din_eop;
    logic [1:0]  din_mty;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic [1:0]  dout_mty;
    logic        flag_port_local_err;
    logic        flag_port_pc_err;
    logic        flag_len_err;

    int errors = 0;
    int checks = 0;

    logic [35:0] oq[$];
    logic [2:0]  fq[$];

    rx_udp_analy dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_port_local      (cfg_port_local),
        .cfg_port_pc         (cfg_port_pc),
        .din                 (din),
        .din_vld             (din_vld),
        .din_sop             (din_sop),
        .din_eop             (din_eop),
        .din_mty             (din_mty),
        .dout                (dout),
        .dout_vld            (dout_vld),
        .dout_sop            (dout_sop),
        .dout_eop            (dout_eop),
        .dout_mty            (dout_mty),
        .flag_port_local_err (flag_port_local_err),
        .flag_port_pc_err    (flag_port_pc_err),
        .flag_len_err        (flag_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [31:0] d, input logic s,
                        input logic e, input logic [1:0] m);
        @(posedge clk);
        #1;
        din     = d;
        din_vld = 1'b1;
        din_sop = s;
        din_eop = e;
        din_mty = m;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        din     = '0;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din_mty = '0;
    endtask

    task automatic exp_word(input logic [31:0] d, input logic s,
                            input logic e, input logic [1:0] m);
        oq.push_back({d, s, e, m});
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] f);
        chk({tag, "_pc"},  {31'd0, flag_port_pc_err},    {31'd0, f[2]});
        chk({tag, "_loc"}, {31'd0, flag_port_local_err}, {31'd0, f[1]});
        chk({tag, "_len"}, {31'd0, flag_len_err},        {31'd0, f[0]});
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        logic [2:0]  f;
        if (rst_n && dout_vld) begin
            if (oq.size() == 0) begin
                chk("unexpected_dout_vld", 32'd1, 32'd0);
            end else begin
                e = oq.pop_front();
                chk("dout",     dout,                  e[35:4]);
                chk("dout_sop", {31'd0, dout_sop},     {31'd0, e[3]});
                chk("dout_eop", {31'd0, dout_eop},     {31'd0, e[2]});
                chk("dout_mty", {30'd0, dout_mty},     {30'd0, e[1:0]});
                if (dout_eop) begin
                    if (fq.size() == 0) begin
                        chk("unexpected_eop_flags", 32'd1, 32'd0);
                    end else begin
                        f = fq.pop_front();
                        chk_flags("eop_flags", f);
                    end
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        cfg_port_pc    = 16'h0bb8;
        cfg_port_local = 16'h1388;
        din            = '0;
        din_vld        = 1'b0;
        din_sop        = 1'b0;
        din_eop        = 1'b0;
        din_mty        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_vld", {31'd0, dout_vld}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk_flags("rst", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // good packet
        exp_word(32'hdeadbeef, 1, 1, 0); fq.push_back(3'b000);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h000cabcd, 0, 0, 0);
        word(32'hdeadbeef, 0, 1, 0);
        idle();

        // odd length, 13 bytes
        exp_word(32'h11223344, 1, 0, 0);
        exp_word(32'h55000000, 0, 1, 3); fq.push_back(3'b000);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h000d0000, 0, 0, 0);
        word(32'h11223344, 0, 0, 0);
        word(32'h55000000, 0, 1, 3);
        idle();

        // length mismatch, flag must hold afterwards
        exp_word(32'h11223344, 1, 0, 0);
        exp_word(32'h55000000, 0, 1, 3); fq.push_back(3'b001);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h00100000, 0, 0, 0);
        word(32'h11223344, 0, 0, 0);
        word(32'h55000000, 0, 1, 3);
        idle();
        repeat (4) idle();
        chk_flags("len_hold", 3'b001);

        // port errors
        exp_word(32'hcafef00d, 1, 1, 0); fq.push_back(3'b110);
        word(32'h0bb71387, 1, 0, 0);
        word(32'h000c1234, 0, 0, 0);
        word(32'hcafef00d, 0, 1, 0);
        idle();
        idle();

        // truncated: sop+eop on a single word
        word(32'h0bb81388, 1, 1, 0);
        idle();
        chk("trunc_no_dout", {31'd0, dout_vld}, 32'd0);
        chk_flags("trunc", 3'b001);
        idle();

        // header-only packet
        word(32'h0bb81388, 1, 0, 0);
        word(32'h00080000, 0, 1, 0);
        idle();
        chk("hdronly_no_dout", {31'd0, dout_vld}, 32'd0);
        chk_flags("hdronly", 3'b000);
        idle();

        // abort by new sop after 2 payload words, then normal packet
        exp_word(32'h01010101, 1, 0, 0);
        exp_word(32'h02020202, 0, 0, 0);
        exp_word(32'h00000000, 0, 1, 0); fq.push_back(3'b001);
        exp_word(32'h0a0b0c0d, 1, 1, 0); fq.push_back(3'b000);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h00140000, 0, 0, 0);
        word(32'h01010101, 0, 0, 0);
        word(32'h02020202, 0, 0, 0);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h000c0000, 0, 0, 0);
        word(32'h0a0b0c0d, 0, 1, 0);
        idle();
        idle();

        // async reset mid-DATA, after a length error has set a flag
        word(32'h0bb81388, 1, 1, 0);
        idle();
        exp_word(32'h77777777, 1, 0, 0);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h00100000, 0, 0, 0);
        word(32'h77777777, 0, 0, 0);
        idle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout_vld", {31'd0, dout_vld}, 32'd0);
        chk("mid_rst_dout", dout, 32'd0);
        chk_flags("mid_rst", 3'b000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // back-to-back, no idle gap
        exp_word(32'h12345678, 1, 1, 0); fq.push_back(3'b000);
        exp_word(32'h9abcdef0, 1, 1, 0); fq.push_back(3'b010);
        word(32'h0bb81388, 1, 0, 0);
        word(32'h000c0000, 0, 0, 0);
        word(32'h12345678, 0, 1, 0);
        word(32'h0bb81387, 1, 0, 0);
        word(32'h000c0000, 0, 0, 0);
        word(32'h9abcdef0, 0, 1, 0);
        idle();
        repeat (4) idle();
        chk_flags("b2b_hold", 3'b010);

        chk("oq_drained", oq.size(), 32'd0);
        chk("fq_drained", fq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
